audio_sample_feeder: RTL and testbench
======================================

Name: audio_sample_feeder

Overview:
- CPU-facing stereo sample buffer sitting directly upstream of the I2S output stage.
- CPU pushes packed L/R 16-bit pairs over a simple register bus into a FIFO.
- On each slot request from the I2S stage, the block presents the next channel sample, volume-scaled.
- Handles underrun, flush and low-watermark interrupt.

Parameters:
- DEPTH, 256, FIFO depth in 32-bit stereo words; power of two, 4..4096.
- LEVEL_W, $clog2(DEPTH)+1, width of the fill-level counter.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  bus request; held until o_ready.
- i_rw  in  1  1=write, 0=read.
- i_address  in  2  register select.
- i_wdata  in  32  write data.
- o_rdata  out  32  read data, valid while o_ready=1.
- o_ready  out  1  one-cycle completion pulse.
- o_interrupt  out  1  low-watermark level interrupt.
- i_output_busy  in  1  I2S stage busy; a one-cycle low pulse marks a slot request.
- o_sample  out  16  signed sample to the I2S stage.

Behaviour:
- Interface: one clock (i_clock); reset (i_reset) is synchronous and active-high.
- Reset values: o_ready=0, o_rdata=0, o_interrupt=0, o_sample=0.
- Reset internal state: FIFO empty, phase=LEFT, enable=0, volume=128, threshold=DEPTH/4, underrun=0.
- Bus handshake: a request is accepted in cycle N; o_ready=1 in cycle N+1 for exactly one cycle.
- Bus handshake: i_request must drop or re-issue after o_ready; no second acceptance while o_ready=1.
- Reg 0, DATA (W): push {R[31:16], L[15:0]}.
  - If the FIFO is full, acceptance stalls (no o_ready) until a pop frees space; then push and ack.
  - Reads return 0.
- Reg 1, CONTROL (RW): [0] enable, [1] flush (write-only, self-clearing, reads 0), [15:8] volume (unsigned), [31:16] threshold (zero-extended to LEVEL_W).
- Flush empties the FIFO and clears the holding register in the cycle of acceptance; phase is not changed.
- Reg 2, STATUS (R): [15:0] fill level, [31:16] underrun count (saturates at 0xFFFF). Any write to reg 2 clears the underrun count.
- Reg 3: reads 0, writes are ignored and acked.
- Slot request: i_output_busy==0, sampled on a clock edge. o_sample updates on that same edge and holds until the next request. The I2S stage latches it 1 cycle later.
- Phase toggles LEFT<->RIGHT on every request, even when disabled, so L/R alignment with LRCK is preserved.
- LEFT request, enable=1, FIFO not empty: pop one word; o_sample<=scale(L); holding reg<=R.
- LEFT request, enable=1, FIFO empty: underrun. o_sample<=0, holding<=0, underrun++ (saturating). No pop.
- RIGHT request: o_sample<=scale(holding).
- enable=0: o_sample<=0, no pop, no underrun counting.
- Pop and push on the same edge: both happen; level is unchanged.
- Flush on the same edge as a pop: flush wins; the popped L is still output.
- scale(x) = saturate16((x signed × volume unsigned) >>> 7), computed in 25-bit signed. volume 128 = unity, 0 = mute, 255 ≈ ×1.99. Saturate to 0x7FFF / 0x8000.
- o_interrupt (registered) = enable && level <= threshold; updates 1 cycle after a level change.
- Back-to-back requests, with i_output_busy low for consecutive cycles, are each served.

Decomposition:
- Shared package audio_pkg:
  - Register address constants (ADDR_DATA=0, ADDR_CONTROL=1, ADDR_STATUS=2).
  - CONTROL bit positions.
  - Phase enum (LEFT, RIGHT).
  - VOLUME_UNITY=128.
- One sub-module audio_fifo: synchronous single-clock FIFO of DEPTH×32 with push, pop, flush, full, empty and level outputs. Read data is registered on pop.
- Scaling and saturation stay inline.

Test Plan:
- Reset, write CONTROL=0x0040_8001 (enable, vol 128, thr 64), push 0x1234_5678, pulse busy low twice -> o_sample=0x5678, then 0x1234; level 1->0.
- Enable with empty FIFO, 3 LEFT+RIGHT slot pairs -> o_sample stays 0, STATUS[31:16]=3. Write STATUS -> count reads 0.
- Volume 64, push {0x8000, 0x7FFF}, then volume 255 with same data -> half vol: 0x3FFF, 0xC000; vol 255: saturate 0x7FFF, 0x8000.
- Push DEPTH words, then a further push -> o_ready withheld. One LEFT slot -> push completes with o_ready pulse; level stays DEPTH.
- Threshold 4, fill 6, consume 2 LEFT slots -> o_interrupt rises 1 cycle after level reaches 4. Flush -> level 0, interrupt stays 1.
- Reset asserted mid-stream with level 10 and phase RIGHT -> next cycle: level 0, o_sample=0, enable=0. After re-enable and a push, first request outputs L.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg -- register map, control bit positions, phase type and sample scaler
// Rev 1.0
`default_nettype none

package audio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_VOL_LSB    = 8;
  localparam int CTRL_THR_LSB    = 16;

  localparam logic [7:0] VOLUME_UNITY = 8'd128;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } phase_e;

  // Volume is Q1.7 unsigned: 128 is unity gain, so the product is shifted back by 7.
  function automatic logic [15:0] scale_sample(input logic [15:0] x, input logic [7:0] vol);
    logic signed [24:0] prod;
    prod = $signed(x) * $signed({1'b0, vol});
    prod = prod >>> 7;
    if (prod > 25'sd32767)
      return 16'h7FFF;
    else if (prod < -25'sd32768)
      return 16'h8000;
    else
      return prod[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_fifo.sv
// audio_fifo -- single-clock DEPTH x 32 FIFO; head word is registered and always shows mem[rd_ptr]
// Rev 1.0
`default_nettype none

module audio_fifo #(
  parameter int DEPTH   = 256,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [31:0]        wdata_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [31:0]        rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        rdata_q;
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      rd_ptr_d;
  logic [LEVEL_W-1:0] level_q;
  logic               do_push;
  logic               do_pop;

  assign full_o   = (level_q == LEVEL_W'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign do_push  = push_i && (!full_o || pop_i);
  assign do_pop   = pop_i && !empty_o;
  assign rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  assign rdata_o  = rdata_q;
  assign level_o  = level_q;

  // Bypass covers a write landing in the slot that becomes the new head.
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem_q[wr_ptr_q] <= wdata_i;
    if (do_push && (wr_ptr_q == rd_ptr_d))
      rdata_q <= wdata_i;
    else
      rdata_q <= mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (do_push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_sample_feeder.sv
// audio_sample_feeder -- CPU-fed stereo FIFO that serves volume-scaled L/R samples to an I2S stage
// Rev 1.0
`default_nettype none

module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [1:0]  i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt,
  input  logic        i_output_busy,
  output logic [15:0] o_sample
);

  logic               ready_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rdata_d;
  logic               irq_q;
  logic [15:0]        sample_q;
  phase_e             phase_q;
  logic               enable_q;
  logic [7:0]         volume_q;
  logic [15:0]        threshold_q;
  logic [15:0]        underrun_q;
  logic [15:0]        hold_q;

  logic [31:0]        fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;

  logic slot, pop, data_wr, accept, push, flush, ctrl_wr, stat_wr;

  assign slot    = !i_output_busy;
  assign pop     = slot && (phase_q == LEFT) && enable_q && !fifo_empty;
  assign data_wr = i_request && i_rw && (i_address == ADDR_DATA);
  // A DATA write into a full FIFO may still go through on the edge that pops.
  assign accept  = i_request && !ready_q && !(data_wr && fifo_full && !pop);
  assign push    = accept && data_wr;
  assign ctrl_wr = accept && i_rw && (i_address == ADDR_CONTROL);
  assign stat_wr = accept && i_rw && (i_address == ADDR_STATUS);
  assign flush   = ctrl_wr && i_wdata[CTRL_FLUSH_BIT];

  always_comb begin
    rdata_d = '0;
    if (accept && !i_rw) begin
      case (i_address)
        ADDR_CONTROL: rdata_d = {threshold_q, volume_q, 7'b0, enable_q};
        ADDR_STATUS:  rdata_d = {underrun_q, 16'(fifo_level)};
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      sample_q    <= '0;
      phase_q     <= LEFT;
      enable_q    <= 1'b0;
      volume_q    <= VOLUME_UNITY;
      threshold_q <= 16'(DEPTH / 4);
      underrun_q  <= '0;
      hold_q      <= '0;
    end else begin
      ready_q <= accept;
      rdata_q <= rdata_d;
      irq_q   <= enable_q && (16'(fifo_level) <= threshold_q);

      if (ctrl_wr) begin
        enable_q    <= i_wdata[CTRL_ENABLE_BIT];
        volume_q    <= i_wdata[CTRL_VOL_LSB +: 8];
        threshold_q <= i_wdata[CTRL_THR_LSB +: 16];
      end

      if (slot) begin
        phase_q <= (phase_q == LEFT) ? RIGHT : LEFT;
        if (!enable_q) begin
          sample_q <= '0;
        end else if (phase_q == LEFT) begin
          if (fifo_empty) begin
            sample_q <= '0;
            hold_q   <= '0;
            if (underrun_q != 16'hFFFF)
              underrun_q <= underrun_q + 16'd1;
          end else begin
            sample_q <= scale_sample(fifo_rdata[15:0], volume_q);
            hold_q   <= fifo_rdata[31:16];
          end
        end else begin
          sample_q <= scale_sample(hold_q, volume_q);
        end
      end

      if (flush)
        hold_q <= '0;
      if (stat_wr)
        underrun_q <= '0;
    end
  end

  audio_fifo #(
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) u_fifo (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .push_i  (push),
    .wdata_i (i_wdata),
    .pop_i   (pop),
    .flush_i (flush),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign o_ready     = ready_q;
  assign o_rdata     = rdata_q;
  assign o_interrupt = irq_q;
  assign o_sample    = sample_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_feeder.sv
// tb_audio_sample_feeder -- scoreboard bench: reference model predicts each slot sample and register read
// Rev 1.0
`default_nettype none

module tb_audio_sample_feeder;
  import audio_pkg::*;

  localparam int DEPTH   = 16;
  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_request;
  logic        i_rw;
  logic [1:0]  i_address;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_interrupt;
  logic        i_output_busy;
  logic [15:0] o_sample;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sb[$];
  logic [31:0] mq[$];
  bit          m_phase;
  bit          m_en;
  logic [15:0] m_hold;
  logic [15:0] m_und;
  logic [7:0]  m_vol;
  logic [15:0] m_thr;

  always #5 clk = ~clk;

  audio_sample_feeder #(
    .DEPTH   (DEPTH),
    .LEVEL_W (LEVEL_W)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_request     (i_request),
    .i_rw          (i_rw),
    .i_address     (i_address),
    .i_wdata       (i_wdata),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready),
    .o_interrupt   (o_interrupt),
    .i_output_busy (i_output_busy),
    .o_sample      (o_sample)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_scale(input logic [15:0] x, input logic [7:0] v);
    int p;
    p = int'($signed(x)) * int'(v);
    p = p >>> 7;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_phase = 1'b0;
    m_en    = 1'b0;
    m_hold  = '0;
    m_und   = '0;
    m_vol   = 8'd128;
    m_thr   = 16'(DEPTH / 4);
  endtask

  task automatic model_slot(output logic [15:0] e);
    logic [31:0] w;
    e = '0;
    if (m_en) begin
      if (!m_phase) begin
        if (mq.size() > 0) begin
          w      = mq.pop_front();
          e      = ref_scale(w[15:0], m_vol);
          m_hold = w[31:16];
        end else begin
          m_hold = '0;
          if (m_und != 16'hFFFF) m_und = m_und + 16'd1;
        end
      end else begin
        e = ref_scale(m_hold, m_vol);
      end
    end
    m_phase = !m_phase;
  endtask

  task automatic slot(output logic [15:0] got);
    logic [15:0] e;
    model_slot(e);
    sb.push_back(e);
    i_output_busy = 1'b0;
    @(posedge clk); #1;
    i_output_busy = 1'b1;
    got = o_sample;
    check("sample", {16'h0, o_sample}, {16'h0, sb.pop_front()});
  endtask

  task automatic bus_xfer(input logic rw, input logic [1:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    i_request = 1'b1; i_rw = rw; i_address = a; i_wdata = d;
    for (int n = 0; n < 50 && !got; n++) begin
      @(posedge clk); #1;
      if (o_ready) begin
        got = 1;
        rd  = o_rdata;
      end
    end
    i_request = 1'b0;
    if (!got) check("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus_xfer(1'b1, a, d, rd);
    if (a == ADDR_DATA) begin
      mq.push_back(d);
    end else if (a == ADDR_CONTROL) begin
      m_en  = d[0];
      m_vol = d[15:8];
      m_thr = d[31:16];
      if (d[1]) begin
        mq.delete();
        m_hold = '0;
      end
    end else if (a == ADDR_STATUS) begin
      m_und = '0;
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] rd);
    bus_xfer(1'b0, a, 32'h0, rd);
  endtask

  task automatic status_check(input string tag);
    logic [31:0] rd;
    bus_read(ADDR_STATUS, rd);
    check(tag, rd, {m_und, 16'(mq.size())});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [15:0] s;
    bit          stall_ack;

    rst = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_address = '0; i_wdata = '0;
    i_output_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    check("rst_ready", {31'h0, o_ready}, 32'd0);
    check("rst_rdata", o_rdata, 32'd0);
    check("rst_irq", {31'h0, o_interrupt}, 32'd0);
    check("rst_sample", {16'h0, o_sample}, 32'd0);
    bus_read(ADDR_CONTROL, rd);
    check("rst_control", rd, {16'(DEPTH / 4), 8'd128, 8'h00});
    status_check("rst_status");

    // Disabled slots still toggle phase and output silence.
    slot(s); slot(s);

    // Unity volume, one stereo word.
    bus_write(ADDR_CONTROL, 32'h0040_8001);
    bus_write(ADDR_DATA, 32'h1234_5678);
    status_check("level_one");
    slot(s); check("t1_left", {16'h0, s}, 32'h5678);
    status_check("level_zero");
    slot(s); check("t1_right", {16'h0, s}, 32'h1234);

    // Underruns on an empty, enabled FIFO.
    repeat (6) slot(s);
    bus_read(ADDR_STATUS, rd);
    check("underrun_3", {16'h0, rd[31:16]}, 32'd3);
    bus_write(ADDR_STATUS, 32'h0);
    bus_read(ADDR_STATUS, rd);
    check("underrun_clr", {16'h0, rd[31:16]}, 32'd0);

    // Half volume, then near-double with saturation.
    bus_write(ADDR_CONTROL, {16'h0040, 8'd64, 8'h01});
    bus_write(ADDR_DATA, 32'h8000_7FFF);
    slot(s); check("vol64_L", {16'h0, s}, 32'h3FFF);
    slot(s); check("vol64_R", {16'h0, s}, 32'hC000);
    bus_write(ADDR_CONTROL, {16'h0040, 8'd255, 8'h01});
    bus_write(ADDR_DATA, 32'h8000_7FFF);
    slot(s); check("vol255_L", {16'h0, s}, 32'h7FFF);
    slot(s); check("vol255_R", {16'h0, s}, 32'h8000);

    // Fill to DEPTH; an extra push stalls until a LEFT slot pops.
    bus_write(ADDR_CONTROL, {16'h0040, 8'd128, 8'h01});
    for (int i = 0; i < DEPTH; i++)
      bus_write(ADDR_DATA, {16'(i + 16'h0100), 16'(i + 16'h0200)});
    status_check("full_level");
    i_request = 1'b1; i_rw = 1'b1; i_address = ADDR_DATA; i_wdata = 32'hCAFE_F00D;
    stall_ack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_ready) stall_ack = 1;
    end
    check("full_no_ack", {31'h0, stall_ack}, 32'd0);
    model_slot(s);
    sb.push_back(s);
    i_output_busy = 1'b0;
    @(posedge clk); #1;
    i_output_busy = 1'b1;
    check("full_ack", {31'h0, o_ready}, 32'd1);
    check("full_pop_sample", {16'h0, o_sample}, {16'h0, sb.pop_front()});
    i_request = 1'b0;
    mq.push_back(32'hCAFE_F00D);
    @(posedge clk); #1;
    status_check("full_level_kept");
    slot(s);
    bus_write(ADDR_CONTROL, {16'h0040, 8'd128, 8'h03});

    // Low-watermark interrupt, then flush.
    bus_write(ADDR_CONTROL, {16'd4, 8'd128, 8'h01});
    for (int i = 0; i < 6; i++) bus_write(ADDR_DATA, 32'h0001_0001 * (i + 1));
    @(posedge clk); #1;
    check("irq_above", {31'h0, o_interrupt}, 32'd0);
    slot(s); slot(s); slot(s);
    check("irq_lag", {31'h0, o_interrupt}, 32'd0);
    @(posedge clk); #1;
    check("irq_set", {31'h0, o_interrupt}, 32'd1);
    bus_write(ADDR_CONTROL, {16'd4, 8'd128, 8'h03});
    status_check("flush_level");
    check("irq_after_flush", {31'h0, o_interrupt}, 32'd1);

    // Reset mid-stream with level 10 and phase RIGHT.
    slot(s);
    for (int i = 0; i < 11; i++) bus_write(ADDR_DATA, 32'h0303_0404 + i);
    slot(s);
    status_check("pre_reset_level");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("mid_rst_sample", {16'h0, o_sample}, 32'd0);
    status_check("mid_rst_status");
    bus_read(ADDR_CONTROL, rd);
    check("mid_rst_control", rd, {16'(DEPTH / 4), 8'd128, 8'h00});
    bus_write(ADDR_CONTROL, {16'(DEPTH / 4), 8'd128, 8'h01});
    bus_write(ADDR_DATA, 32'hAAAA_5555);
    slot(s); check("post_rst_L", {16'h0, s}, 32'h5555);
    slot(s); check("post_rst_R", {16'h0, s}, 32'hAAAA);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
